mem_arbiter: RTL and testbench

Parametrised N-port arbiter between the cache/MMU masters (icache, dcache, Sv32 page-table walker) and the single shared memory port. It replaces combinational `is_instruction` steering with a registered grant FSM. The FSM latches one master's request, holds it stable on the memory bus until `mem_ready_i`, and returns the response only to that master. Arbitration is round-robin or fixed-priority, selected by parameter.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the master-side request/response signals and the
// shared memory port seen by mem_arbiter.
//   port_valid_i/addr/wdata/wmask : per-master request, flattened (port i at
//                                   [i*W +: W])
//   port_rdata_o/port_ready_o     : per-master response, ready is a 1-cycle pulse
//   mem_*                         : single shared memory request/response
//   grant_o                       : one-hot current owner (zero when idle)
// Modports: slave = arbiter side, master = masters + memory side.
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]          port_valid_i;
  logic [NUM_PORTS*ADDR_W-1:0]   port_addr_i;
  logic [NUM_PORTS*DATA_W-1:0]   port_wdata_i;
  logic [NUM_PORTS*DATA_W/8-1:0] port_wmask_i;
  logic [NUM_PORTS*DATA_W-1:0]   port_rdata_o;
  logic [NUM_PORTS-1:0]          port_ready_o;
  logic                          mem_valid_o;
  logic [ADDR_W-1:0]             mem_addr_o;
  logic [DATA_W-1:0]             mem_wdata_o;
  logic [DATA_W/8-1:0]           mem_wmask_o;
  logic [DATA_W-1:0]             mem_rdata_i;
  logic                          mem_ready_i;
  logic [NUM_PORTS-1:0]          grant_o;

  modport slave (
    input  port_valid_i, port_addr_i, port_wdata_i, port_wmask_i,
    output port_rdata_o, port_ready_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i, mem_ready_i,
    output grant_o
  );

  modport master (
    output port_valid_i, port_addr_i, port_wdata_i, port_wmask_i,
    input  port_rdata_o, port_ready_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_rdata_i, mem_ready_i,
    input  grant_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered N-port arbiter in front of one shared memory port.
// A winner's request is latched on grant and held on the memory bus until
// mem_ready_i; the response is steered only to the granted master.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : mem_arbiter_if.slave (master requests, responses, memory port, grant)
// Parameters: NUM_PORTS (2..8), ADDR_W, DATA_W, FIXED_PRIO (0 = round-robin,
// 1 = lowest index wins).

// Per-port response steering: a port sees ready/rdata only while it owns the
// bus and memory completes; otherwise its slice is forced to zero.
module mem_arbiter_lane #(
  parameter int DATA_W = 32
) (
  input  logic              gnt,
  input  logic              done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);
  assign ready = gnt & done;
  assign rdata = ready ? mem_rdata : '0;
endmodule

module mem_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_PORTS-1:0][MASK_W-1:0] wmask_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;
  logic [NUM_PORTS-1:0]             ready_v;

  logic [IDX_W-1:0]     last, win_idx, cand;
  logic                 win_found, do_grant, done;
  logic [NUM_PORTS-1:0] grant;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [MASK_W-1:0]    wmask_q;

  assign addr_v  = bus.port_addr_i;
  assign wdata_v = bus.port_wdata_i;
  assign wmask_v = bus.port_wmask_i;

  // Winner selection. Fixed priority scans downward so the lowest valid index
  // is the last one written. Round-robin scans last+1 .. last with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (bus.port_valid_i[IDX_W'(i)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = IDX_W'((int'(last) + k) % NUM_PORTS);
        if (!win_found && bus.port_valid_i[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // Next-state: IDLE grants whenever anything is pending; BUSY waits for
  // memory. Returning through IDLE forces a one-cycle gap between grants.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    case (state)
      IDLE: if (win_found) begin
        do_grant  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (bus.mem_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_ready_i only counts while a request is outstanding.
  assign done = (state == BUSY) && bus.mem_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= IDX_W'(NUM_PORTS - 1);
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        // Only this copy reaches memory; later changes on the port are ignored.
        addr_q  <= addr_v[win_idx];
        wdata_q <= wdata_v[win_idx];
        wmask_q <= wmask_v[win_idx];
        grant   <= NUM_PORTS'(1) << win_idx;
        if (FIXED_PRIO == 0) last <= win_idx;
      end else if (done) begin
        grant <= '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    mem_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .gnt       (grant[i]),
      .done      (done),
      .mem_rdata (bus.mem_rdata_i),
      .ready     (ready_v[i]),
      .rdata     (rdata_v[i])
    );
  end

  // Valid is decoded from the state register so reset drops it immediately.
  assign bus.mem_valid_o  = (state == BUSY);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_wmask_o  = wmask_q;
  assign bus.grant_o      = grant;
  assign bus.port_ready_o = ready_v;
  assign bus.port_rdata_o = rdata_v;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a round-robin instance (u_rr) and
// a fixed-priority instance (u_fp). Stimulus pushes expected grants and
// responses into per-DUT queues; a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) a_if ();
  mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) b_if ();

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset), .bus(a_if));
  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset), .bus(b_if));

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } rsp_t;

  req_t req_q[2][$];
  rsp_t rsp_q[2][$];
  req_t cur[2];
  bit   prev_v[2];
  bit   prev_done[2];
  int   done_cnt[2];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int d, input logic mv, input logic [NP-1:0] gnt,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wm, input logic [NP-1:0] rdy,
                     input logic [NP*DW-1:0] rd);
    req_t r;
    rsp_t s;
    logic [NP*DW-1:0] exp_rd;
    if (reset) begin
      prev_v[d]    = 1'b0;
      prev_done[d] = 1'b0;
      return;
    end
    if (prev_done[d]) chk("idle_gap", 96'(mv), 96'(0));
    if (!mv) begin
      chk("grant_idle", 96'(gnt), 96'(0));
    end else if (!prev_v[d]) begin
      if (req_q[d].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant dut=%0d actual=%b required=none", d, gnt);
      end else begin
        r = req_q[d].pop_front();
        cur[d] = r;
        chk("grant", 96'(gnt), 96'(NP'(1) << r.port));
        chk("req_addr", 96'(addr), 96'(r.addr));
        chk("req_wdata", 96'(wdata), 96'(r.wdata));
        chk("req_wmask", 96'(wm), 96'(r.mask));
      end
    end else begin
      chk("req_hold", 96'({addr, wdata, wm}), 96'({cur[d].addr, cur[d].wdata, cur[d].mask}));
    end
    if (rdy != '0) begin
      if (rsp_q[d].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready dut=%0d actual=%b required=none", d, rdy);
      end else begin
        s = rsp_q[d].pop_front();
        exp_rd = '0;
        exp_rd[s.port*DW +: DW] = s.rdata;
        chk("ready", 96'(rdy), 96'(NP'(1) << s.port));
        chk("rdata", 96'(rd), 96'(exp_rd));
      end
      done_cnt[d]++;
    end
    prev_v[d]    = mv;
    prev_done[d] = (rdy != '0);
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, a_if.mem_valid_o, a_if.grant_o, a_if.mem_addr_o, a_if.mem_wdata_o,
        a_if.mem_wmask_o, a_if.port_ready_o, a_if.port_rdata_o);
    mon(1, b_if.mem_valid_o, b_if.grant_o, b_if.mem_addr_o, b_if.mem_wdata_o,
        b_if.mem_wmask_o, b_if.port_ready_o, b_if.port_rdata_o);
  end

  task automatic set_port(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic v);
    a_if.port_addr_i[p*AW +: AW]  = addr;
    a_if.port_wdata_i[p*DW +: DW] = wdata;
    a_if.port_wmask_i[p*MW +: MW] = mask;
    a_if.port_valid_i[p]          = v;
  endtask

  task automatic wait_done(input int d, input int n, input int budget);
    int t = 0;
    while (done_cnt[d] < n && t < budget) begin
      tick();
      t++;
    end
    if (done_cnt[d] < n) begin
      checks++;
      failures++;
      $display("FAIL timeout dut=%0d completions=%0d required=%0d", d, done_cnt[d], n);
    end
  endtask

  // One transaction on the RR instance: grant, optional field corruption after
  // grant, `waits` BUSY cycles without ready, then completion.
  task automatic run_txn(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input int waits, input logic [31:0] rd,
                         input bit alter);
    req_q[0].push_back('{p, addr, wdata, mask});
    set_port(p, addr, wdata, mask, 1'b1);
    tick();
    if (alter) set_port(p, ~addr, ~wdata, ~mask, 1'b1);
    repeat (waits) tick();
    a_if.mem_rdata_i = rd;
    a_if.mem_ready_i = 1'b1;
    rsp_q[0].push_back('{p, rd});
    tick();
    a_if.mem_ready_i = 1'b0;
    set_port(p, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
  endtask

  initial begin
    a_if.port_valid_i = '0; a_if.port_addr_i = '0; a_if.port_wdata_i = '0;
    a_if.port_wmask_i = '0; a_if.mem_rdata_i = '0; a_if.mem_ready_i = 1'b0;
    b_if.port_valid_i = '0; b_if.port_addr_i = '0; b_if.port_wdata_i = '0;
    b_if.port_wmask_i = '0; b_if.mem_rdata_i = '0; b_if.mem_ready_i = 1'b0;
    reset = 1'b1;
    repeat (2) tick();

    chk("rst_mem_valid", 96'(a_if.mem_valid_o), 96'(0));
    chk("rst_grant", 96'(a_if.grant_o), 96'(0));
    chk("rst_addr", 96'(a_if.mem_addr_o), 96'(0));
    chk("rst_ready", 96'(a_if.port_ready_o), 96'(0));
    chk("rst_rdata", 96'(a_if.port_rdata_o), 96'(0));
    chk("rst_fp_valid", 96'(b_if.mem_valid_o), 96'(0));
    reset = 1'b0;
    tick();

    // Reset while BUSY: port 1 write is dropped with no ready pulse.
    req_q[0].push_back('{1, 32'h44, 32'hAAAA_5555, 4'hF});
    set_port(1, 32'h44, 32'hAAAA_5555, 4'hF, 1'b1);
    tick();
    tick();
    chk("busy_before_reset", 96'(a_if.mem_valid_o), 96'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 96'(a_if.mem_valid_o), 96'(0));
    chk("async_rst_grant", 96'(a_if.grant_o), 96'(0));
    chk("async_rst_addr", 96'(a_if.mem_addr_o), 96'(0));
    chk("async_rst_wdata", 96'(a_if.mem_wdata_o), 96'(0));
    chk("async_rst_wmask", 96'(a_if.mem_wmask_o), 96'(0));
    chk("async_rst_ready", 96'(a_if.port_ready_o), 96'(0));
    set_port(1, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Round-robin with all ports pending: port 0 first after reset, then 1,2,0,1,2.
    for (int p = 0; p < NP; p++) set_port(p, 32'h100 + 32'(4 * p), 32'h0, 4'h0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      req_q[0].push_back('{n % NP, 32'h100 + 32'(4 * (n % NP)), 32'h0, 4'h0});
      rsp_q[0].push_back('{n % NP, 32'h1111_2222});
    end
    done_cnt[0] = 0;
    a_if.mem_rdata_i = 32'h1111_2222;
    a_if.mem_ready_i = 1'b1;
    wait_done(0, 6, 40);
    a_if.port_valid_i = '0;
    a_if.mem_ready_i  = 1'b0;
    tick();

    // Single read with three wait cycles.
    run_txn(1, 32'h8000_0010, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0);
    // Write whose port fields change after grant; memory must see the originals.
    run_txn(2, 32'h20, 32'h1234_5678, 4'b0011, 2, 32'h0, 1'b1);

    // Abandoned request: last owner is port 2, so 0 wins over 1, drops valid
    // mid-transaction, still completes, then port 1 is granted.
    req_q[0].push_back('{0, 32'h300, 32'h0, 4'h0});
    req_q[0].push_back('{1, 32'h304, 32'h0, 4'h0});
    set_port(0, 32'h300, 32'h0, 4'h0, 1'b1);
    set_port(1, 32'h304, 32'h0, 4'h0, 1'b1);
    tick();
    tick();
    tick();
    set_port(0, 32'h300, 32'h0, 4'h0, 1'b0);
    tick();
    a_if.mem_rdata_i = 32'h0BAD_F00D;
    a_if.mem_ready_i = 1'b1;
    rsp_q[0].push_back('{0, 32'h0BAD_F00D});
    tick();
    a_if.mem_rdata_i = 32'h5555_AAAA;
    rsp_q[0].push_back('{1, 32'h5555_AAAA});
    tick();
    tick();
    a_if.mem_ready_i = 1'b0;
    set_port(1, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();

    // Fixed priority: ports 0 and 2 pending, 0 keeps winning until it drops.
    b_if.port_addr_i[0*AW +: AW] = 32'h200;
    b_if.port_addr_i[2*AW +: AW] = 32'h208;
    for (int n = 0; n < 3; n++) begin
      req_q[1].push_back('{0, 32'h200, 32'h0, 4'h0});
      rsp_q[1].push_back('{0, 32'h7777_0000});
    end
    req_q[1].push_back('{2, 32'h208, 32'h0, 4'h0});
    rsp_q[1].push_back('{2, 32'h7777_0000});
    done_cnt[1] = 0;
    b_if.mem_rdata_i  = 32'h7777_0000;
    b_if.mem_ready_i  = 1'b1;
    b_if.port_valid_i = 3'b101;
    wait_done(1, 3, 30);
    b_if.port_valid_i = 3'b100;
    wait_done(1, 4, 30);
    b_if.port_valid_i = '0;
    b_if.mem_ready_i  = 1'b0;
    tick();
    tick();

    chk("rr_req_left", 96'(req_q[0].size()), 96'(0));
    chk("rr_rsp_left", 96'(rsp_q[0].size()), 96'(0));
    chk("fp_req_left", 96'(req_q[1].size()), 96'(0));
    chk("fp_rsp_left", 96'(rsp_q[1].size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
